matrix_operand_loader: RTL and testbench

//  APB-write-side operand front end of the matrix engine: CPU writes A/B operand rows over APB.
//  On a CTRL start the block issues both matrices as flat buses to the systolic array with a valid/ready handshake.
//  It then waits for the engine's finish pulse. This is the CPU->engine direction, complementing the scratchpad's

---
 rtl/matrix_engine_pkg.sv | 31 +++
 rtl/mol_apb_regif.sv | 115 +++++++++++
 rtl/matrix_operand_loader.sv | 132 +++++++++++++
 tb/tb_matrix_operand_loader.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_engine_pkg.sv
// Shared definitions for the matrix engine operand path: geometry, register map, FSM encoding.
package matrix_engine_pkg;

    localparam int unsigned CTRL_IDX_DEF   = 8;
    localparam int unsigned STATUS_OFFSET  = 1;
    localparam int unsigned A_BASE_IDX     = 0;

    localparam int unsigned CTRL_START_BIT = 0;
    localparam int unsigned CTRL_CLEAR_BIT = 1;

    localparam int unsigned STAT_BUSY_BIT  = 0;
    localparam int unsigned STAT_DONE_BIT  = 1;
    localparam int unsigned STAT_ERR_BIT   = 2;
    localparam int unsigned STAT_WIDTH     = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } mol_state_e;

    // One matrix row per APB word.
    function automatic int unsigned max_dim(input int unsigned bus_w, input int unsigned data_w);
        return bus_w / data_w;
    endfunction

    function automatic int unsigned b_base_idx(input int unsigned dim);
        return A_BASE_IDX + dim;
    endfunction

endpackage

// File: rtl/mol_apb_regif.sv
// APB register interface of the operand loader: address decode, read data, error response,
// and the A/B operand register array.
module mol_apb_regif
    import matrix_engine_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned BUS_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned CTRL_IDX   = CTRL_IDX_DEF,
    localparam int unsigned MAX_DIM   = max_dim(BUS_WIDTH, DATA_WIDTH)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         psel,
    input  logic                         penable,
    input  logic                         pwrite,
    input  logic [ADDR_WIDTH-1:0]        paddr,
    input  logic [BUS_WIDTH-1:0]         pwdata,
    output logic [BUS_WIDTH-1:0]         prdata,
    output logic                         pready,
    output logic                         pslverr,
    input  logic                         busy,
    input  logic [STAT_WIDTH-1:0]        status,
    output logic                         start_c,
    output logic                         done_clr_c,
    output logic                         err_clr_c,
    output logic [MAX_DIM*BUS_WIDTH-1:0] op_a_flat,
    output logic [MAX_DIM*BUS_WIDTH-1:0] op_b_flat
);

    localparam int unsigned ROWS     = 2 * MAX_DIM;
    localparam int unsigned ROW_AW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned STAT_IDX = CTRL_IDX + STATUS_OFFSET;
    localparam int unsigned B_BASE   = b_base_idx(MAX_DIM);

    logic [BUS_WIDTH-1:0] rows [ROWS];
    logic                 setup;
    logic                 access;
    logic [31:0]          word;
    logic                 is_op;
    logic                 is_ctrl;
    logic                 is_stat;
    logic                 mapped;
    logic [ROW_AW-1:0]    row_sel;
    logic                 op_wr;
    logic                 clr_wr;
    logic                 status_rd;
    logic [BUS_WIDTH-1:0] rd_mux;
    logic                 unused_addr_bits;

    assign unused_addr_bits = ^paddr[1:0];

    // Decode of the current APB phase; commits happen on the access-cycle edge.
    always_comb begin
        setup     = psel & ~penable;
        access    = psel & penable;
        word      = 32'(paddr[ADDR_WIDTH-1:2]);
        is_op     = (word < ROWS);
        is_ctrl   = (word == CTRL_IDX);
        is_stat   = (word == STAT_IDX);
        mapped    = is_op | is_ctrl | is_stat;
        row_sel   = ROW_AW'(word);
        op_wr     = access & pwrite & is_op & ~busy;
        clr_wr    = access & pwrite & is_ctrl & pwdata[CTRL_CLEAR_BIT] & ~busy;
        start_c   = access & pwrite & is_ctrl & pwdata[CTRL_START_BIT];
        status_rd = access & ~pwrite & is_stat;
        // Only flags the CPU actually saw are cleared, so a flag set during the read survives.
        done_clr_c = status_rd & prdata[STAT_DONE_BIT];
        err_clr_c  = status_rd & prdata[STAT_ERR_BIT];
        rd_mux    = '0;
        if (is_op) begin
            rd_mux = rows[row_sel];
        end else if (is_stat) begin
            rd_mux = BUS_WIDTH'(status);
        end
    end

    assign pready = access;

`ifdef MOL_PSLVERR_EN
    assign pslverr = access & (~mapped
                               | (pwrite & is_stat)
                               | (~pwrite & is_ctrl)
                               | (pwrite & is_op & busy)
                               | (start_c & busy));
`else
    assign pslverr = 1'b0;
`endif

    // Operand rows; clear takes priority and both are locked out while busy.
    always_ff @(posedge clk) begin
        if (reset || clr_wr) begin
            for (int i = 0; i < int'(ROWS); i++) begin
                rows[i] <= '0;
            end
        end else if (op_wr) begin
            rows[row_sel] <= pwdata;
        end
    end

    // Read data is captured in the setup cycle for zero-wait-state return.
    always_ff @(posedge clk) begin
        if (reset) begin
            prdata <= '0;
        end else if (setup && !pwrite) begin
            prdata <= rd_mux;
        end
    end

    for (genvar r = 0; r < int'(MAX_DIM); r++) begin : g_flat
        assign op_a_flat[r*BUS_WIDTH +: BUS_WIDTH] = rows[A_BASE_IDX + r];
        assign op_b_flat[r*BUS_WIDTH +: BUS_WIDTH] = rows[B_BASE + r];
    end

endmodule

// File: rtl/matrix_operand_loader.sv
// Operand front end of the matrix engine: APB-loaded A/B rows issued to the array on start.
// Optional APB error responses are enabled with MOL_PSLVERR_EN.
module matrix_operand_loader
    import matrix_engine_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned BUS_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned CTRL_IDX   = CTRL_IDX_DEF,
    localparam int unsigned MAX_DIM   = max_dim(BUS_WIDTH, DATA_WIDTH)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         psel,
    input  logic                         penable,
    input  logic                         pwrite,
    input  logic [ADDR_WIDTH-1:0]        paddr,
    input  logic [BUS_WIDTH-1:0]         pwdata,
    output logic [BUS_WIDTH-1:0]         prdata,
    output logic                         pready,
    output logic                         pslverr,
    output logic [MAX_DIM*BUS_WIDTH-1:0] op_a_flat,
    output logic [MAX_DIM*BUS_WIDTH-1:0] op_b_flat,
    output logic                         op_valid,
    input  logic                         op_ready,
    input  logic                         engine_done,
    output logic                         busy,
    output logic                         irq
);

    mol_state_e            state;
    mol_state_e            state_next;
    logic                  start_c;
    logic                  done_clr_c;
    logic                  err_clr_c;
    logic                  start_ok;
    logic                  start_busy;
    logic                  finish;
    logic                  done;
    logic                  err;
    logic [STAT_WIDTH-1:0] status;

    always_comb begin
        status                = '0;
        status[STAT_BUSY_BIT] = busy;
        status[STAT_DONE_BIT] = done;
        status[STAT_ERR_BIT]  = err;
    end

    mol_apb_regif #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUS_WIDTH  (BUS_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .CTRL_IDX   (CTRL_IDX)
    ) u_regif (
        .clk        (clk),
        .reset      (reset),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .prdata     (prdata),
        .pready     (pready),
        .pslverr    (pslverr),
        .busy       (busy),
        .status     (status),
        .start_c    (start_c),
        .done_clr_c (done_clr_c),
        .err_clr_c  (err_clr_c),
        .op_a_flat  (op_a_flat),
        .op_b_flat  (op_b_flat)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus the single-cycle events that drive the flags.
    always_comb begin
        state_next = state;
        start_ok   = 1'b0;
        start_busy = 1'b0;
        finish     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_c) begin
                    start_ok   = 1'b1;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                start_busy = start_c;
                if (op_ready) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                start_busy = start_c;
                if (engine_done) begin
                    finish     = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Handshake and status outputs, registered from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_valid <= 1'b0;
            busy     <= 1'b0;
            irq      <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            op_valid <= (state_next == ST_ISSUE);
            busy     <= (state_next != ST_IDLE);
            irq      <= finish;
            done     <= finish | (done & ~start_ok & ~done_clr_c);
            err      <= start_busy | (err & ~err_clr_c);
        end
    end

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Directed self-checking bench for matrix_operand_loader (DATA 16, BUS 32, CTRL word 8).
module tb_matrix_operand_loader;

    localparam int unsigned DW = 16;
    localparam int unsigned BW = 32;
    localparam int unsigned AW = 6;
    localparam int unsigned MD = 2;

    localparam logic [AW-1:0] A_A0   = 6'h00;
    localparam logic [AW-1:0] A_A1   = 6'h04;
    localparam logic [AW-1:0] A_B0   = 6'h08;
    localparam logic [AW-1:0] A_B1   = 6'h0C;
    localparam logic [AW-1:0] A_UNM  = 6'h10;
    localparam logic [AW-1:0] A_CTRL = 6'h20;
    localparam logic [AW-1:0] A_STAT = 6'h24;

`ifdef MOL_PSLVERR_EN
    localparam logic PSLV = 1'b1;
`else
    localparam logic PSLV = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             psel;
    logic             penable;
    logic             pwrite;
    logic [AW-1:0]    paddr;
    logic [BW-1:0]    pwdata;
    logic [BW-1:0]    prdata;
    logic             pready;
    logic             pslverr;
    logic [MD*BW-1:0] op_a_flat;
    logic [MD*BW-1:0] op_b_flat;
    logic             op_valid;
    logic             op_ready;
    logic             engine_done;
    logic             busy;
    logic             irq;

    int checks = 0;
    int errors = 0;

    logic [BW-1:0] rd;
    logic          rdy;
    logic          serr;

    matrix_operand_loader #(
        .DATA_WIDTH (DW),
        .BUS_WIDTH  (BW),
        .ADDR_WIDTH (AW),
        .CTRL_IDX   (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .prdata      (prdata),
        .pready      (pready),
        .pslverr     (pslverr),
        .op_a_flat   (op_a_flat),
        .op_b_flat   (op_b_flat),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .engine_done (engine_done),
        .busy        (busy),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Setup and access phases each last one cycle; bus returns idle afterwards.
    task automatic apb_write(input logic [AW-1:0] a, input logic [BW-1:0] d,
                             output logic r, output logic e);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(negedge clk);
        penable = 1'b1;
        #1;
        r = pready; e = pslverr;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [AW-1:0] a, input logic done_pulse,
                            output logic [BW-1:0] d, output logic r, output logic e);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(negedge clk);
        penable = 1'b1; engine_done = done_pulse;
        #1;
        d = prdata; r = pready; e = pslverr;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; engine_done = 1'b0;
    endtask

    initial begin
        reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; op_ready = 1'b0; engine_done = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_prdata", 128'(prdata), 128'(0));
        chk("rst_pready", 128'(pready), 128'(0));
        chk("rst_op_valid", 128'(op_valid), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_irq", 128'(irq), 128'(0));
        chk("rst_op_a", 128'(op_a_flat), 128'(0));
        reset = 1'b0;

        // 1: row writes and readback
        apb_write(A_A0, 32'h0002_0001, rdy, serr);
        chk("t1_wr_pready", 128'(rdy), 128'(1));
        chk("t1_wr_pslverr", 128'(serr), 128'(0));
        apb_write(A_A1, 32'h0004_0003, rdy, serr);
        apb_write(A_B0, 32'h0006_0005, rdy, serr);
        apb_write(A_B1, 32'h0008_0007, rdy, serr);
        apb_read(A_A0, 1'b0, rd, rdy, serr);
        chk("t1_rd_a0", 128'(rd), 128'h0002_0001);
        chk("t1_rd_pready", 128'(rdy), 128'(1));
        apb_read(A_A1, 1'b0, rd, rdy, serr);
        chk("t1_rd_a1", 128'(rd), 128'h0004_0003);
        apb_read(A_B0, 1'b0, rd, rdy, serr);
        chk("t1_rd_b0", 128'(rd), 128'h0006_0005);
        apb_read(A_B1, 1'b0, rd, rdy, serr);
        chk("t1_rd_b1", 128'(rd), 128'h0008_0007);
        apb_read(A_UNM, 1'b0, rd, rdy, serr);
        chk("t1_rd_unmapped", 128'(rd), 128'(0));
        chk("t1_unmapped_pslverr", 128'(serr), 128'(PSLV));
        apb_read(A_CTRL, 1'b0, rd, rdy, serr);
        chk("t1_rd_ctrl", 128'(rd), 128'(0));
        chk("t1_ctrl_rd_pslverr", 128'(serr), 128'(PSLV));

        // engine_done while idle is ignored
        @(negedge clk); engine_done = 1'b1;
        @(negedge clk); engine_done = 1'b0;
        chk("idle_done_irq", 128'(irq), 128'(0));
        apb_read(A_STAT, 1'b0, rd, rdy, serr);
        chk("idle_done_status", 128'(rd), 128'(0));

        // 2: start with op_ready held low
        apb_write(A_CTRL, 32'h1, rdy, serr);
        chk("t2_op_valid", 128'(op_valid), 128'(1));
        chk("t2_busy", 128'(busy), 128'(1));
        chk("t2_op_a", 128'(op_a_flat), 128'h0004_0003_0002_0001);
        chk("t2_op_b", 128'(op_b_flat), 128'h0008_0007_0006_0005);
        repeat (3) @(negedge clk);
        chk("t2_valid_held", 128'(op_valid), 128'(1));
        op_ready = 1'b1;
        @(negedge clk);
        op_ready = 1'b0;
        chk("t2_valid_drop", 128'(op_valid), 128'(0));
        chk("t2_busy_wait", 128'(busy), 128'(1));

        // 3: write ignored in WAIT, then finish
        apb_write(A_A0, 32'hFFFF_FFFF, rdy, serr);
        chk("t3_busy_wr_pslverr", 128'(serr), 128'(PSLV));
        apb_read(A_A0, 1'b0, rd, rdy, serr);
        chk("t3_a0_kept", 128'(rd), 128'h0002_0001);
        chk("t3_op_a_kept", 128'(op_a_flat), 128'h0004_0003_0002_0001);
        engine_done = 1'b1;
        @(negedge clk);
        engine_done = 1'b0;
        chk("t3_busy_low", 128'(busy), 128'(0));
        chk("t3_irq", 128'(irq), 128'(1));
        @(negedge clk);
        chk("t3_irq_pulse", 128'(irq), 128'(0));
        apb_read(A_STAT, 1'b0, rd, rdy, serr);
        chk("t3_status_done", 128'(rd), 128'h2);
        apb_read(A_STAT, 1'b0, rd, rdy, serr);
        chk("t3_status_clr", 128'(rd), 128'h0);
        apb_write(A_STAT, 32'h7, rdy, serr);
        chk("t3_stat_wr_pslverr", 128'(serr), 128'(PSLV));

        // 4: start while busy
        apb_write(A_CTRL, 32'h1, rdy, serr);
        chk("t4_first_start_pslverr", 128'(serr), 128'(0));
        apb_write(A_CTRL, 32'h1, rdy, serr);
        chk("t4_start_busy_pslverr", 128'(serr), 128'(PSLV));
        chk("t4_still_issue", 128'(op_valid), 128'(1));
        apb_read(A_STAT, 1'b0, rd, rdy, serr);
        chk("t4_status_err", 128'(rd), 128'h5);
        apb_read(A_STAT, 1'b0, rd, rdy, serr);
        chk("t4_status_errclr", 128'(rd), 128'h1);

        // 5: reset during ISSUE
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        chk("t5_op_valid", 128'(op_valid), 128'(0));
        chk("t5_busy", 128'(busy), 128'(0));
        chk("t5_op_a", 128'(op_a_flat), 128'(0));
        apb_read(A_A0, 1'b0, rd, rdy, serr);
        chk("t5_a0", 128'(rd), 128'(0));
        apb_read(A_A1, 1'b0, rd, rdy, serr);
        chk("t5_a1", 128'(rd), 128'(0));
        apb_read(A_B0, 1'b0, rd, rdy, serr);
        chk("t5_b0", 128'(rd), 128'(0));
        apb_read(A_B1, 1'b0, rd, rdy, serr);
        chk("t5_b1", 128'(rd), 128'(0));

        // 6: clear and start together
        apb_write(A_A0, 32'h0000_1234, rdy, serr);
        apb_write(A_B1, 32'h0000_5678, rdy, serr);
        chk("t6_preload", 128'(op_a_flat), 128'h0000_0000_0000_1234);
        apb_write(A_CTRL, 32'h3, rdy, serr);
        chk("t6_op_valid", 128'(op_valid), 128'(1));
        chk("t6_op_a_zero", 128'(op_a_flat), 128'(0));
        chk("t6_op_b_zero", 128'(op_b_flat), 128'(0));
        op_ready = 1'b1;
        @(negedge clk);
        op_ready = 1'b0;
        // STATUS read whose access edge coincides with engine_done
        apb_read(A_STAT, 1'b1, rd, rdy, serr);
        chk("t6_status_pre", 128'(rd), 128'h1);
        chk("t6_irq", 128'(irq), 128'(1));
        apb_read(A_STAT, 1'b0, rd, rdy, serr);
        chk("t6_done_survives", 128'(rd), 128'h2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
